data_cache_controller: RTL and testbench
========================================

DATA_CACHE_CONTROLLER -- requirements
Module: data_cache_controller

Interface
REQ-001 SHALL: CLK  in  1  clock; all state changes on rising edge.
REQ-002 SHALL: RESET  in  1  synchronous, active-high reset.
REQ-003 SHALL: READ  in  1  CPU load request from MEM stage.
REQ-004 SHALL: WRITE  in  1  CPU store request from MEM stage.
REQ-005 SHALL: ADDRESS  in  32  CPU byte address; [1:0] ignored, [3:2] word offset, [6:4] index, [31:7] tag.
REQ-006 SHALL: WRITEDATA  in  32  store data.
REQ-007 SHALL: READDATA  out  32  load data, valid whenever BUSYWAIT is low.
REQ-008 SHALL: BUSYWAIT  out  1  stall to PC, pipeline registers and MEM/WB.
REQ-009 SHALL: MEM_READ  out  1  main-memory block read strobe.
REQ-010 SHALL: MEM_WRITE  out  1  main-memory block write strobe.
REQ-011 SHALL: MEM_ADDRESS  out  28  block address {tag,index}.
REQ-012 SHALL: MEM_WRITEDATA  out  128  evicted block, word 0 in [31:0].
REQ-013 SHALL: MEM_READDATA  in  128  fetched block, word 0 in [31:0].
REQ-014 SHALL: MEM_BUSYWAIT  in  1  memory busy; a low level completes a transfer.

Function
REQ-015 SHALL: geometry is direct-mapped, 8 lines x 4 words, write-back, write-allocate; each line holds valid, dirty, 25-bit tag.
REQ-016 SHALL: hit = valid[index] && tag[index]==ADDRESS[31:7], evaluated only in IDLE.
REQ-017 SHALL: FSM states are IDLE, WRITEBACK, FETCH, ALLOCATE.
REQ-018 SHALL: in IDLE, BUSYWAIT = (READ|WRITE) && !hit, driven combinationally; BUSYWAIT is high in every other state.
REQ-019 SHALL: a read hit drives READDATA combinationally from the selected word, with zero extra cycles.
REQ-020 SHALL: a write hit updates the selected word and sets dirty at the next edge.
REQ-021 SHALL: a miss moves IDLE->WRITEBACK if the victim is valid && dirty, otherwise IDLE->FETCH.
REQ-022 SHALL: in WRITEBACK, MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITEDATA=victim block; the FSM moves to FETCH on the first edge with MEM_BUSYWAIT low.
REQ-023 SHALL: in FETCH, MEM_READ=1 and MEM_ADDRESS=ADDRESS[31:4]; the FSM moves to ALLOCATE on the first edge with MEM_BUSYWAIT low, capturing MEM_READDATA.
REQ-024 SHALL: ALLOCATE writes the captured block with valid=1, dirty=0 and the new tag, then returns to IDLE, where the access completes as a hit.
REQ-025 SHALL: MEM_READ and MEM_WRITE are never high together, and both are low in IDLE and ALLOCATE.
REQ-026 SHALL: when READ and WRITE are both high, the access is treated as a write.
REQ-027 SHALL: the CPU holds ADDRESS, READ, WRITE and WRITEDATA stable while BUSYWAIT is high; the controller does not re-sample them.

Reset
REQ-028 SHALL: with RESET high at an edge, state=IDLE and every valid and dirty bit is cleared, including mid-WRITEBACK or mid-FETCH; an in-flight memory transfer is abandoned.
REQ-029 SHALL: while RESET is high, READDATA=0, BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0 and MEM_WRITEDATA=0.
REQ-030 SHALL: data and tag arrays need no reset.

Configuration
REQ-031 SHALL: macro DCACHE_STATS_EN, when defined, adds outputs HIT_COUNT (out 32) and MISS_COUNT (out 32).
REQ-032 SHALL: counter rules are: +1 per access completing as a first-cycle hit, +1 per IDLE->WRITEBACK/FETCH transition; both cleared by RESET; both wrap at 2^32.
REQ-033 SHALL: without DCACHE_STATS_EN, the ports and counters do not exist and all other behaviour is identical.

Structure
REQ-034 SHALL: shared package dcache_pkg holds the state enum and constants LINES=8, WORDS=4, INDEX_W=3, TAG_W=25, BLOCK_W=128.
REQ-035 SHALL: storage (data, tag, valid, dirty arrays plus word select and word merge) lives in sub-module dcache_line_array; the FSM lives in the top module.

Verification
REQ-036 SHALL: read 0x0000_0040 after reset -> BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=0x0000004; after MEM_BUSYWAIT falls, ALLOCATE then IDLE; READDATA = MEM_READDATA word 0; BUSYWAIT=0.
REQ-037 SHALL: write 0xDEADBEEF to 0x44 after REQ-036 -> hit, no memory strobe; a following read of 0x44 returns 0xDEADBEEF with BUSYWAIT=0.
REQ-038 SHALL: read 0x0000_00C0 (same index, new tag) after REQ-037 -> WRITEBACK with MEM_ADDRESS=0x0000004 and MEM_WRITEDATA[63:32]=0xDEADBEEF, then FETCH with MEM_ADDRESS=0x000000C.
REQ-039 SHALL: RESET asserted during FETCH with MEM_BUSYWAIT=1 -> next cycle IDLE, MEM_READ=0, BUSYWAIT=0; re-reading 0xC0 misses.
REQ-040 SHALL: READ and WRITE both high on a hit to 0x48 with WRITEDATA=0x1234 -> word updated, dirty set, no stall.
REQ-041 SHALL: with DCACHE_STATS_EN defined, after REQ-036 to REQ-038 -> HIT_COUNT=2, MISS_COUNT=2.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry constants and controller state encoding for the direct-mapped data cache.
package dcache_pkg;

  localparam int LINES    = 8;
  localparam int WORDS    = 4;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 25;
  localparam int BLOCK_W  = 128;
  localparam int OFFSET_W = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for the data cache: data/tag/valid/dirty arrays with word select and word merge.
// Lookups are combinational on index/offset; writes, fills and clear land on the rising edge.
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic [INDEX_W-1:0] index,
  input  logic [OFFSET_W-1:0] offset,
  input  logic               word_we,
  input  logic [31:0]        word_wdata,
  input  logic               fill_we,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_block,
  output logic               line_valid,
  output logic               line_dirty,
  output logic [TAG_W-1:0]   line_tag,
  output logic [BLOCK_W-1:0] line_block,
  output logic [31:0]        rd_word
);

  logic [BLOCK_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [BLOCK_W-1:0] merged;

  assign line_valid = valid_q[index];
  assign line_dirty = dirty_q[index];
  assign line_tag   = tag_q[index];
  assign line_block = data_q[index];
  assign rd_word    = data_q[index][offset*32 +: 32];

  always_comb begin
    merged = data_q[index];
    merged[offset*32 +: 32] = word_wdata;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid bits alone decide whether contents matter.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[index] <= fill_block;
      tag_q[index]  <= fill_tag;
    end else if (word_we) begin
      data_q[index] <= merged;
    end
  end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller; hits complete in the request cycle.
// Optional HIT_COUNT/MISS_COUNT statistics outputs are built when DCACHE_STATS_EN is defined.
module data_cache_controller
  import dcache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [31:0]        ADDRESS,
  input  logic [31:0]        WRITEDATA,
  output logic [31:0]        READDATA,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [27:0]        MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]        HIT_COUNT,
  output logic [31:0]        MISS_COUNT
`endif
);

  state_t              state_q, state_d;
  logic [BLOCK_W-1:0]  fetch_q;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] offset;
  logic                access, hit, in_idle;
  logic                word_we, fill_we;
  logic                line_valid, line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_block;
  logic [31:0]         rd_word;
  logic                unused_addr_bits;

  assign index            = ADDRESS[6:4];
  assign tag              = ADDRESS[31:7];
  assign offset           = ADDRESS[3:2];
  assign unused_addr_bits = ^ADDRESS[1:0];

  assign access  = READ | WRITE;
  assign in_idle = (state_q == IDLE);
  assign hit     = line_valid && (line_tag == tag);
  // WRITE wins when both strobes are high, so a combined request behaves as a store.
  assign word_we = !RESET && in_idle && WRITE && hit;
  assign fill_we = !RESET && (state_q == ALLOCATE);

  dcache_line_array u_lines (
    .clk        (CLK),
    .clear      (RESET),
    .index      (index),
    .offset     (offset),
    .word_we    (word_we),
    .word_wdata (WRITEDATA),
    .fill_we    (fill_we),
    .fill_tag   (tag),
    .fill_block (fetch_q),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_block (line_block),
    .rd_word    (rd_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (access && !hit) state_d = (line_valid && line_dirty) ? WRITEBACK : FETCH;
      WRITEBACK: if (!MEM_BUSYWAIT) state_d = FETCH;
      FETCH:     if (!MEM_BUSYWAIT) state_d = ALLOCATE;
      ALLOCATE:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (state_q == FETCH && !MEM_BUSYWAIT) fetch_q <= MEM_READDATA;
  end

  always_comb begin
    READDATA      = '0;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    if (!RESET) begin
      READDATA = rd_word;
      BUSYWAIT = in_idle ? (access && !hit) : 1'b1;
      case (state_q)
        WRITEBACK: begin
          MEM_WRITE     = 1'b1;
          MEM_ADDRESS   = {line_tag, index};
          MEM_WRITEDATA = line_block;
        end
        FETCH: begin
          MEM_READ    = 1'b1;
          MEM_ADDRESS = ADDRESS[31:4];
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic retry_q;

  // The cycle after ALLOCATE finishes the stalled access; it is not a fresh hit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      retry_q    <= 1'b0;
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      retry_q <= (state_q == ALLOCATE);
      if (in_idle && access && hit && !retry_q) HIT_COUNT  <= HIT_COUNT + 32'd1;
      if (in_idle && access && !hit)            MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Randomized scoreboard bench: flat-memory reference model plus a latency-randomized main memory.
module tb_data_cache_controller;

  logic         CLK = 1'b0;
  logic         RESET, READ, WRITE;
  logic [31:0]  ADDRESS, WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

  data_cache_controller dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference view: the value every word address should read, independent of where it lives.
  logic [31:0]  flat [logic [29:0]];
  logic [127:0] mem  [logic [27:0]];
  bit           mvalid [8];
  bit           mdirty [8];
  logic [24:0]  mtag   [8];
  int           m_hits, m_misses;
  logic [31:0]  rd_q[$];
  logic [27:0]  wb_q[$];
  logic [27:0]  fetch_q[$];
  bit           mem_hold = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    logic [31:0] w;
    w = {2'b00, wa} * 32'h9E37_79B1;
    return w ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] back_word(input logic [29:0] wa);
    logic [127:0] b;
    if (mem.exists(wa[29:2])) begin
      b = mem[wa[29:2]];
      return b[wa[1:0]*32 +: 32];
    end
    return init_word(wa);
  endfunction

  function automatic logic [31:0] flat_rd(input logic [29:0] wa);
    if (flat.exists(wa)) return flat[wa];
    return back_word(wa);
  endfunction

  function automatic logic [127:0] back_block(input logic [27:0] ba);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = back_word({ba, w[1:0]});
    return b;
  endfunction

  function automatic logic [127:0] flat_block(input logic [27:0] ba);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[w*32 +: 32] = flat_rd({ba, w[1:0]});
    return b;
  endfunction

  // Reset discards any dirty data still held only in the cache.
  task automatic model_reset();
    flat.delete();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
    rd_q.delete();
    wb_q.delete();
    fetch_q.delete();
  endtask

  // Main memory: random latency per transfer, one-cycle completion pulse.
  initial begin
    int lat;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    lat = -1;
    forever begin
      @(posedge CLK); #1;
      if (!RESET && !mem_hold && (MEM_READ || MEM_WRITE)) begin
        if (lat < 0) lat = $urandom_range(0, 3);
        if (lat == 0) begin
          MEM_BUSYWAIT = 1'b0;
          MEM_READDATA = back_block(MEM_ADDRESS);
          lat = -1;
        end else begin
          MEM_BUSYWAIT = 1'b1;
          lat--;
        end
      end else begin
        MEM_BUSYWAIT = 1'b1;
        lat = -1;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RESET && !MEM_BUSYWAIT && (MEM_READ || MEM_WRITE)) begin
      if (MEM_READ && MEM_WRITE) chk("strobe_exclusive", 1, 0);
      if (MEM_WRITE) begin
        if (wb_q.size() == 0) chk("unexpected_writeback", MEM_ADDRESS, 0);
        else begin
          logic [27:0] ea;
          ea = wb_q.pop_front();
          chk("wb_address", MEM_ADDRESS, ea);
          chk("wb_data", MEM_WRITEDATA, flat_block(ea));
        end
        mem[MEM_ADDRESS] = MEM_WRITEDATA;
      end else begin
        if (fetch_q.size() == 0) chk("unexpected_fetch", MEM_ADDRESS, 0);
        else chk("fetch_address", MEM_ADDRESS, fetch_q.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (!RESET && READ && !WRITE && !BUSYWAIT) begin
      if (rd_q.size() == 0) chk("unexpected_read", READDATA, 0);
      else chk("read_data", READDATA, rd_q.pop_front());
    end
  end

  // Called and returns at posedge+1; holds the request until BUSYWAIT drops.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [2:0]  idx;
    logic [24:0] tg;
    logic [29:0] wa;
    bit          exp_hit;
    int          n;
    idx = addr[6:4];
    tg  = addr[31:7];
    wa  = addr[31:2];
    exp_hit = mvalid[idx] && (mtag[idx] == tg);
    if (!exp_hit && mvalid[idx] && mdirty[idx]) wb_q.push_back({mtag[idx], idx});
    if (!exp_hit) fetch_q.push_back(addr[31:4]);
    if (rd && !wr) rd_q.push_back(flat_rd(wa));
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    @(negedge CLK);
    chk("first_cycle_busywait", BUSYWAIT, !exp_hit);
    if (exp_hit) chk("hit_no_strobe", {MEM_READ, MEM_WRITE}, 2'b00);
    n = 0;
    while (BUSYWAIT && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (BUSYWAIT) begin
      $display("FAIL busywait_timeout: got stuck high at addr %0h, required release within 200 cycles", addr);
      $fatal(1);
    end
    @(posedge CLK); #1;
    if (exp_hit) m_hits++;
    else begin
      m_misses++;
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      mdirty[idx] = 1'b0;
    end
    if (wr) begin
      mdirty[idx] = 1'b1;
      flat[wa] = wd;
    end
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_readdata"}, READDATA, 0);
    chk({nm, "_busywait"}, BUSYWAIT, 0);
    chk({nm, "_strobes"}, {MEM_READ, MEM_WRITE}, 0);
    chk({nm, "_mem_address"}, MEM_ADDRESS, 0);
    chk({nm, "_mem_writedata"}, MEM_WRITEDATA, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 32'h40; WRITEDATA = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("reset");
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;

    // Cold read miss, then store hit, read-back, and dirty eviction.
    do_access(1, 0, 32'h0000_0040, 0);
    do_access(0, 1, 32'h0000_0044, 32'hDEAD_BEEF);
    do_access(1, 0, 32'h0000_0044, 0);
    do_access(1, 0, 32'h0000_00C0, 0);
`ifdef DCACHE_STATS_EN
    chk("hit_count_directed", HIT_COUNT, 2);
    chk("miss_count_directed", MISS_COUNT, 2);
`endif

    // Reset while a fetch is stalled by memory.
    mem_hold = 1'b1;
    READ = 1'b1; ADDRESS = 32'h0000_0240;
    @(negedge CLK);
    chk("clean_miss_busywait", BUSYWAIT, 1);
    @(negedge CLK);
    chk("fetch_strobe", MEM_READ, 1);
    chk("fetch_addr_held", MEM_ADDRESS, 28'h24);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk_reset_outputs("mid_fetch_reset");
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;
    mem_hold = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("post_reset_mem_read", MEM_READ, 0);
    chk("post_reset_busywait", BUSYWAIT, 0);
    @(posedge CLK); #1;
    do_access(1, 0, 32'h0000_00C0, 0);

    // Combined READ+WRITE on a hit acts as a store.
    do_access(1, 0, 32'h0000_0048, 0);
    do_access(1, 1, 32'h0000_0048, 32'h0000_1234);
    do_access(1, 0, 32'h0000_0048, 0);
    do_access(1, 0, 32'h0000_01C8, 0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int          kind;
      a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      if (kind < 5)      do_access(1, 0, a, 0);
      else if (kind < 9) do_access(0, 1, a, $urandom);
      else               do_access(1, 1, a, $urandom);
      if ($urandom_range(0, 3) == 0) @(posedge CLK);
    end

`ifdef DCACHE_STATS_EN
    chk("hit_count_final", HIT_COUNT, m_hits);
    chk("miss_count_final", MISS_COUNT, m_misses);
`endif
    chk("read_queue_drained", rd_q.size(), 0);
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("fetch_queue_drained", fetch_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
